// File: rtl/ram_stream_loader.sv
// Purpose: writes one valid/ready frame into a single-port RAM, reads it back and compares additive checksums.
// Latency: the write happens on the beat's own edge; DONE is entered DEPTH+1 cycles after the final load beat.
// Backpressure: s_ready is high only in LOAD; s_valid=0 cycles stall the load with no side effects.
module ram_stream_loader #(
    parameter int DEPTH  = 784,
    parameter int WIDTH  = 4,
    parameter int CSUM_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_last,
    output logic              mem_wen,
    output logic [AW-1:0]     mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              ok,
    output logic              err_len,
    output logic [AW:0]       count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_VERIFY,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t            state;
    logic [AW-1:0]     ptr;
    logic [CSUM_W-1:0] wr_sum;
    logic [CSUM_W-1:0] rd_sum;

    logic              beat;
    logic              at_last;
    logic [CSUM_W-1:0] s_data_ext;
    logic [CSUM_W-1:0] rdata_ext;
    logic [CSUM_W-1:0] rd_sum_next;

    // Status and handshake outputs are plain decodes of the state register.
    assign s_ready     = (state == S_LOAD);
    assign busy        = (state == S_LOAD) || (state == S_VERIFY) || (state == S_DRAIN);
    assign done        = (state == S_DONE);

    assign beat        = s_valid && s_ready;
    assign at_last     = (ptr == LAST);
    assign s_data_ext  = CSUM_W'(s_data);
    assign rdata_ext   = CSUM_W'(mem_rdata);
    assign rd_sum_next = rd_sum + rdata_ext;

    // The write is combinational off the beat so RAM captures it on the beat's own edge.
    assign mem_wen     = beat;
    assign mem_wdata   = s_data;

    // Address follows ptr while the frame is active and parks at 0 otherwise.
    always_comb begin
        mem_addr = '0;
        case (state)
            S_LOAD, S_VERIFY, S_DRAIN: mem_addr = ptr;
            default:                   mem_addr = '0;
        endcase
    end

    // Frame sequencer: load DEPTH beats, sweep DEPTH read addresses, drain the last read, report.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            ptr     <= '0;
            count   <= '0;
            wr_sum  <= '0;
            rd_sum  <= '0;
            err_len <= 1'b0;
            ok      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_LOAD;
                        ptr     <= '0;
                        count   <= '0;
                        wr_sum  <= '0;
                        rd_sum  <= '0;
                        err_len <= 1'b0;
                        ok      <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        count   <= count + 1'b1;
                        wr_sum  <= wr_sum + s_data_ext;
                        // s_last is only checked for position; it never shortens the frame.
                        err_len <= err_len | (s_last != at_last);
                        if (at_last) begin
                            state <= S_VERIFY;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                S_VERIFY: begin
                    // Read data lags the address by one cycle, so the first cycle has nothing to add.
                    if (ptr != '0) begin
                        rd_sum <= rd_sum_next;
                    end
                    if (at_last) begin
                        state <= S_DRAIN;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                S_DRAIN: begin
                    rd_sum <= rd_sum_next;
                    ok     <= (rd_sum_next == wr_sum) && !err_len;
                    state  <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_loader.sv
module tb_ram_stream_loader;

    typedef struct {
        logic [2:0] a;
        logic [3:0] d;
    } wr_t;

    typedef struct {
        logic       ok;
        logic       err;
        logic [3:0] cnt;
    } res_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance (DEPTH=8)
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       mem_wen;
    logic [2:0] mem_addr;
    logic [3:0] mem_wdata;
    logic [3:0] mem_rdata;
    logic       busy, done, ok, err_len;
    logic [3:0] count;

    ram_stream_loader #(.DEPTH(8), .WIDTH(4), .CSUM_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .ok(ok), .err_len(err_len), .count(count)
    );

    // Full-size instance (DEPTH=784)
    logic        s1_start = 1'b0;
    logic        s1_valid = 1'b0;
    logic        s1_ready;
    logic [3:0]  s1_data = '0;
    logic        s1_last = 1'b0;
    logic        m1_wen;
    logic [9:0]  m1_addr;
    logic [3:0]  m1_wdata;
    logic [3:0]  m1_rdata;
    logic        b1_busy, b1_done, b1_ok, b1_err;
    logic [10:0] b1_count;

    ram_stream_loader #(.DEPTH(784), .WIDTH(4), .CSUM_W(16)) u1 (
        .clk(clk), .rst_n(rst_n), .start(s1_start),
        .s_valid(s1_valid), .s_ready(s1_ready), .s_data(s1_data), .s_last(s1_last),
        .mem_wen(m1_wen), .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
        .busy(b1_busy), .done(b1_done), .ok(b1_ok), .err_len(b1_err), .count(b1_count)
    );

    // RAM models: registered read, optional corruption of address 3 on the small one
    logic       corrupt = 1'b0;
    logic [3:0] ram0 [8];
    logic [3:0] ram1 [784];

    always @(posedge clk) begin
        if (mem_wen) ram0[mem_addr] <= mem_wdata;
        mem_rdata <= (corrupt && mem_addr == 3'd3) ? 4'hF : ram0[mem_addr];
        if (m1_wen) ram1[m1_addr] <= m1_wdata;
        m1_rdata <= ram1[m1_addr];
    end

    wr_t  wq[$];
    res_t rq[$];
    int   wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every write issued to the small RAM is checked against the scoreboard
    always @(negedge clk) begin
        if (mem_wen === 1'b1) begin
            wr_cnt++;
            if (wq.size() == 0) begin
                chk("unexpected_write", {29'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("write_addr", {29'd0, mem_addr}, {29'd0, e.a});
                chk("write_data", {28'd0, mem_wdata}, {28'd0, e.d});
            end
        end
    end

    logic [3:0] pat [8];

    task automatic run_frame(input logic [3:0] d [8], input int lastpos, input bit toggle,
                             input bit corrupt_on, input bit check_ram);
        int   wsum, rsum, n;
        res_t r, e;
        wsum = 0;
        rsum = 0;
        for (int i = 0; i < 8; i++) begin
            wsum += int'(d[i]);
            rsum += (corrupt_on && i == 3) ? 15 : int'(d[i]);
        end
        r.err = (lastpos != 7);
        r.ok  = (wsum == rsum) && !r.err;
        r.cnt = 4'd8;
        rq.push_back(r);
        corrupt = corrupt_on;
        wr_cnt  = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("done_after_start", {31'd0, done}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (toggle && i > 0) begin
                s_valid = 1'b0;
                s_data  = 4'hA;
                s_last  = 1'b1;
                @(posedge clk); #1;
            end
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = (i == lastpos);
            wq.push_back('{a: 3'(i), d: d[i]});
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_latency", n, 32'd9);
        e = rq.pop_front();
        chk("ok", {31'd0, ok}, {31'd0, e.ok});
        chk("err_len", {31'd0, err_len}, {31'd0, e.err});
        chk("count", {28'd0, count}, {28'd0, e.cnt});
        chk("num_writes", wr_cnt, 32'd8);
        if (check_ram) begin
            for (int i = 0; i < 8; i++) chk("ram_word", {28'd0, ram0[i]}, {28'd0, d[i]});
        end
    endtask

    initial begin
        int n;
        // Reset state
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_wen", {31'd0, mem_wen}, 32'd0);
        chk("rst_addr", {29'd0, mem_addr}, 32'd0);
        chk("rst_err_len", {31'd0, err_len}, 32'd0);
        @(posedge clk); #1;

        // 1: data 1..8 back-to-back
        for (int i = 0; i < 8; i++) pat[i] = 4'(i + 1);
        run_frame(pat, 7, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("done_held", {31'd0, done}, 32'd1);
        chk("addr_in_done", {29'd0, mem_addr}, 32'd0);

        // 2: same frame with s_valid toggling (RAM pre-scrambled first)
        for (int i = 0; i < 8; i++) pat[i] = 4'(8 - i);
        run_frame(pat, 7, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) pat[i] = 4'(i + 1);
        run_frame(pat, 7, 1'b1, 1'b0, 1'b1);

        // 3: s_last on the 5th word only
        run_frame(pat, 4, 1'b0, 1'b0, 1'b0);

        // 4: corrupted read of address 3
        run_frame(pat, 7, 1'b0, 1'b1, 1'b0);
        corrupt = 1'b0;

        // 5: reset mid-frame after 4 beats, then a clean frame
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 4'(i + 3);
            s_last  = 1'b0;
            wq.push_back('{a: 3'(i), d: 4'(i + 3)});
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_count", {28'd0, count}, 32'd0);
        chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_wq_drained", wq.size(), 32'd0);
        for (int i = 0; i < 8; i++) pat[i] = 4'(i * 2 + 1);
        run_frame(pat, 7, 1'b0, 1'b0, 1'b1);

        // 6: DEPTH=784, all 0xF, start pulsed during LOAD and VERIFY
        s1_start = 1'b1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        for (int i = 0; i < 784; i++) begin
            s1_valid = 1'b1;
            s1_data  = 4'hF;
            s1_last  = (i == 783);
            s1_start = (i % 100 == 5);
            @(posedge clk); #1;
        end
        s1_valid = 1'b0;
        s1_last  = 1'b0;
        n = 0;
        while (b1_done !== 1'b1 && n < 2000) begin
            s1_start = (n < 10);
            @(posedge clk); #1;
            n++;
        end
        s1_start = 1'b0;
        chk("big_done_latency", n, 32'd785);
        chk("big_ok", {31'd0, b1_ok}, 32'd1);
        chk("big_err_len", {31'd0, b1_err}, 32'd0);
        chk("big_count", {21'd0, b1_count}, 32'd784);
        chk("big_ram_last", {28'd0, ram1[783]}, 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
